color_manager_report_tx: RTL and testbench
==========================================

// Module: color_manager_report_tx
// PURPOSE
//  Return path of the Color Manager UART link. Captures notification/error pulses from the
//  configuration manager and the VGA data assigner, formats each as a 5-byte ASCII frame and
//  writes the bytes into the UART TX FIFO. Sits beside Color_Manager; its output feeds the TX FIFO write port.
// PARAMETERS
//  UART_DATA_WIDTH            8  TX FIFO byte width; fixed at 8 (ASCII)
//  CONFIG_NOTIFICATION_WIDTH  4  width of Config_Notification, 1..8
//  CONFIG_ERROR_WIDTH         4  width of Config_Error, 1..8
//  VGA_NOTIFICATION_WIDTH     4  width of VGA_Notification, 1..8
//  DROP_COUNT_WIDTH           8  width of saturating drop counter
// PORTS
//  Clk                        in   1   system clock, rising edge
//  Rst                        in   1   asynchronous, active-low reset
//  Config_Notification        in   CONFIG_NOTIFICATION_WIDTH  config manager notification code
//  Config_Notification_Valid  in   1   1-cycle strobe qualifying Config_Notification
//  Config_Error               in   CONFIG_ERROR_WIDTH         config manager error code
//  Error_Valid                in   1   1-cycle strobe qualifying Config_Error
//  VGA_Notification           in   VGA_NOTIFICATION_WIDTH     VGA assigner notification code
//  VGA_Notification_Valid     in   1   1-cycle strobe qualifying VGA_Notification
//  Full                       in   1   TX FIFO full; no write may occur while high
//  TXD_Data                   out  UART_DATA_WIDTH  byte to TX FIFO
//  TXD_Wr                     out  1   TX FIFO write strobe, one byte per high cycle
//  Busy                       out  1   high while a frame is in progress or any event pending
//  Drop_Count                 out  DROP_COUNT_WIDTH saturating count of lost events
// BEHAVIOUR
//  Reset (Rst=0, async): TXD_Data=0, TXD_Wr=0, Busy=0, Drop_Count=0, all pending cleared, FSM=IDLE.
//  Capture: one pending slot (flag + code) per source. Valid high at edge -> slot set, code latched.
//   Valid while slot already pending -> new event dropped, old code kept, Drop_Count+1 (saturates at all-ones).
//   Valid in the same cycle the FSM consumes that slot -> new event captured (set beats clear), no drop.
//  Arbitration in IDLE, fixed priority: Error > Config notification > VGA notification.
//  Frame: TYPE, HEX_HI, HEX_LO, 0x0D, 0x0A. TYPE = 'E'(0x45) / 'C'(0x43) / 'V'(0x56).
//   Code zero-extended to 8 bits; nibble -> ASCII '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46).
//  FSM: IDLE -> S_TYPE -> S_HI -> S_LO -> S_CR -> S_LF -> IDLE.
//   IDLE: if any slot pending, load frame register from winner, clear its slot, go S_TYPE.
//   S_x: TXD_Wr = !Full (combinational on registered state), TXD_Data = that byte;
//        advance only in a cycle where TXD_Wr=1; Full=1 holds state and TXD_Data stable.
//   After S_LF write, return to IDLE (one idle cycle between frames; arbitration re-run there).
//  Latency: strobe at cycle N -> slot set at end of N -> IDLE loads in N+1 -> TYPE byte written
//   in N+2 if Full=0; full frame occupies N+2..N+6 with Full low throughout.
//  Frame is atomic: a higher-priority event arriving mid-frame waits; it never interrupts.
//  Busy = (state != IDLE) | any slot pending.
//  TXD_Data is 0 in IDLE; TXD_Wr never asserted in IDLE.
//  Rst asserted mid-frame: partial frame abandoned immediately, no further bytes written.
// TESTING
//  1 Error_Valid, Config_Error=4'hA, Full=0 -> TXD_Wr cycles N+2..N+6 bytes 45 30 41 0D 0A; Busy falls at N+7.
//  2 Error, Config(3), VGA(7) strobed same cycle -> frames in order E0?,C03,V07, one idle cycle between each; Drop_Count=0.
//  3 Full held high from 2nd byte for 10 cycles -> no TXD_Wr, TXD_Data stays 0x30; resumes with 0x30 when Full drops.
//  4 Two Config_Notification_Valid 3 cycles apart while C frame sending -> second captured (slot was cleared); third strobe while pending -> dropped, Drop_Count=1, original code sent.
//  5 300 dropped VGA events with Full=1 -> Drop_Count saturates at 8'hFF, no wrap.
//  6 Rst low during S_HI -> TXD_Wr=0 and Busy=0 asynchronously; after release no residual bytes; new event sends a full 5-byte frame.

Source files
------------

// File: rtl/color_manager_report_tx.sv
// Return path of the Color Manager UART link: captures notification/error strobes into
// one pending slot per source and emits each as a 5-byte ASCII frame into the TX FIFO.
module color_manager_report_tx #(
  parameter int UART_DATA_WIDTH           = 8,
  parameter int CONFIG_NOTIFICATION_WIDTH = 4,
  parameter int CONFIG_ERROR_WIDTH        = 4,
  parameter int VGA_NOTIFICATION_WIDTH    = 4,
  parameter int DROP_COUNT_WIDTH          = 8
) (
  input  logic                                 Clk,
  input  logic                                 Rst,
  input  logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification,
  input  logic                                 Config_Notification_Valid,
  input  logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error,
  input  logic                                 Error_Valid,
  input  logic [VGA_NOTIFICATION_WIDTH-1:0]    VGA_Notification,
  input  logic                                 VGA_Notification_Valid,
  input  logic                                 Full,
  output logic [UART_DATA_WIDTH-1:0]           TXD_Data,
  output logic                                 TXD_Wr,
  output logic                                 Busy,
  output logic [DROP_COUNT_WIDTH-1:0]          Drop_Count,
  output logic [2:0]                           Fsm_State
);

  // Handshake: a byte is transferred in every cycle where TXD_Wr=1; TXD_Wr is only
  // raised while Full=0, and TXD_Data is held stable while a byte waits on Full.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_TYPE = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_CR   = 3'd4,
    S_LF   = 3'd5
  } state_t;

  state_t      state;
  logic [7:0]  frame_type;
  logic [7:0]  frame_code;

  logic        err_pend, cfg_pend, vga_pend;
  logic [7:0]  err_code, cfg_code, vga_code;
  logic [7:0]  err_in, cfg_in, vga_in;
  logic        take_err, take_cfg, take_vga;
  logic        drop_err, drop_cfg, drop_vga;
  logic [1:0]  drop_inc;
  logic [DROP_COUNT_WIDTH:0] drop_sum;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    err_in = '0;
    cfg_in = '0;
    vga_in = '0;
    err_in[CONFIG_ERROR_WIDTH-1:0]        = Config_Error;
    cfg_in[CONFIG_NOTIFICATION_WIDTH-1:0] = Config_Notification;
    vga_in[VGA_NOTIFICATION_WIDTH-1:0]    = VGA_Notification;
  end

  // Fixed priority arbitration, only evaluated while idle.
  always_comb begin
    take_err = (state == IDLE) && err_pend;
    take_cfg = (state == IDLE) && !err_pend && cfg_pend;
    take_vga = (state == IDLE) && !err_pend && !cfg_pend && vga_pend;
    drop_err = Error_Valid && err_pend && !take_err;
    drop_cfg = Config_Notification_Valid && cfg_pend && !take_cfg;
    drop_vga = VGA_Notification_Valid && vga_pend && !take_vga;
    drop_inc = 2'(drop_err) + 2'(drop_cfg) + 2'(drop_vga);
    drop_sum = {1'b0, Drop_Count} + (DROP_COUNT_WIDTH+1)'(drop_inc);
  end

  // A strobe landing on the cycle its slot is consumed is captured (set beats clear).
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      err_pend   <= 1'b0;
      cfg_pend   <= 1'b0;
      vga_pend   <= 1'b0;
      err_code   <= '0;
      cfg_code   <= '0;
      vga_code   <= '0;
      Drop_Count <= '0;
    end else begin
      if (Error_Valid && !drop_err) begin
        err_pend <= 1'b1;
        err_code <= err_in;
      end else if (take_err) begin
        err_pend <= 1'b0;
      end
      if (Config_Notification_Valid && !drop_cfg) begin
        cfg_pend <= 1'b1;
        cfg_code <= cfg_in;
      end else if (take_cfg) begin
        cfg_pend <= 1'b0;
      end
      if (VGA_Notification_Valid && !drop_vga) begin
        vga_pend <= 1'b1;
        vga_code <= vga_in;
      end else if (take_vga) begin
        vga_pend <= 1'b0;
      end
      Drop_Count <= drop_sum[DROP_COUNT_WIDTH] ? '1 : drop_sum[DROP_COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      frame_type <= '0;
      frame_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_err) begin
            frame_type <= 8'h45;
            frame_code <= err_code;
            state      <= S_TYPE;
          end else if (take_cfg) begin
            frame_type <= 8'h43;
            frame_code <= cfg_code;
            state      <= S_TYPE;
          end else if (take_vga) begin
            frame_type <= 8'h56;
            frame_code <= vga_code;
            state      <= S_TYPE;
          end
        end
        S_TYPE:  if (TXD_Wr) state <= S_HI;
        S_HI:    if (TXD_Wr) state <= S_LO;
        S_LO:    if (TXD_Wr) state <= S_CR;
        S_CR:    if (TXD_Wr) state <= S_LF;
        S_LF:    if (TXD_Wr) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    TXD_Wr = (state != IDLE) && !Full;
    case (state)
      S_TYPE:  TXD_Data = frame_type;
      S_HI:    TXD_Data = hex_ascii(frame_code[7:4]);
      S_LO:    TXD_Data = hex_ascii(frame_code[3:0]);
      S_CR:    TXD_Data = 8'h0D;
      S_LF:    TXD_Data = 8'h0A;
      default: TXD_Data = '0;
    endcase
  end

  assign Busy      = (state != IDLE) || err_pend || cfg_pend || vga_pend;
  assign Fsm_State = state;

endmodule

// File: tb/tb_color_manager_report_tx.sv
// Bench for color_manager_report_tx: directed scenarios plus random traffic, checked
// against a frame-level reference model with an expected byte queue.
module tb_color_manager_report_tx;

  logic       Clk;
  logic       Rst;
  logic [3:0] Config_Notification;
  logic       Config_Notification_Valid;
  logic [3:0] Config_Error;
  logic       Error_Valid;
  logic [3:0] VGA_Notification;
  logic       VGA_Notification_Valid;
  logic       Full;
  logic [7:0] TXD_Data;
  logic       TXD_Wr;
  logic       Busy;
  logic [7:0] Drop_Count;
  logic [2:0] Fsm_State;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;

  color_manager_report_tx dut (
    .Clk                       (Clk),
    .Rst                       (Rst),
    .Config_Notification       (Config_Notification),
    .Config_Notification_Valid (Config_Notification_Valid),
    .Config_Error              (Config_Error),
    .Error_Valid               (Error_Valid),
    .VGA_Notification          (VGA_Notification),
    .VGA_Notification_Valid    (VGA_Notification_Valid),
    .Full                      (Full),
    .TXD_Data                  (TXD_Data),
    .TXD_Wr                    (TXD_Wr),
    .Busy                      (Busy),
    .Drop_Count                (Drop_Count),
    .Fsm_State                 (Fsm_State)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: sources indexed 0=error, 1=config, 2=vga
  logic [7:0] exp_q[$];
  bit   [2:0] m_pend;
  logic [7:0] m_code [3];
  int         m_rem;
  int         m_drops;

  function automatic logic [7:0] ascii_hex(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  always @(posedge Clk or negedge Rst) begin
    int         win;
    bit   [2:0] v;
    logic [7:0] c [3];
    if (!Rst) begin
      m_pend  = '0;
      m_rem   = 0;
      m_drops = 0;
      exp_q.delete();
    end else begin
      win  = -1;
      v    = {VGA_Notification_Valid, Config_Notification_Valid, Error_Valid};
      c[0] = {4'h0, Config_Error};
      c[1] = {4'h0, Config_Notification};
      c[2] = {4'h0, VGA_Notification};
      if (m_rem == 0) begin
        for (int s = 2; s >= 0; s--) if (m_pend[s]) win = s;
        if (win >= 0) begin
          exp_q.push_back((win == 0) ? 8'h45 : (win == 1) ? 8'h43 : 8'h56);
          exp_q.push_back(ascii_hex(int'(m_code[win]) / 16));
          exp_q.push_back(ascii_hex(int'(m_code[win]) % 16));
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
          m_rem = 5;
        end
      end else if (!Full) begin
        m_rem--;
      end
      for (int s = 0; s < 3; s++) begin
        if (v[s]) begin
          if (m_pend[s] && win != s) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
          else begin
            m_pend[s] = 1'b1;
            m_code[s] = c[s];
          end
        end else if (win == s) begin
          m_pend[s] = 1'b0;
        end
      end
    end
  end

  // scoreboard, sampled mid-cycle
  always @(negedge Clk) begin
    check("wr", {31'b0, TXD_Wr}, {31'b0, (m_rem > 0) && !Full});
    check("busy", {31'b0, Busy}, {31'b0, (m_rem > 0) || (m_pend != 0)});
    check("drops", {24'b0, Drop_Count}, 32'(m_drops));
    if (m_rem > 0 && exp_q.size() > 0) begin
      check("data", {24'b0, TXD_Data}, {24'b0, exp_q[0]});
      if (TXD_Wr) void'(exp_q.pop_front());
    end else begin
      check("idle_data", {24'b0, TXD_Data}, 32'h0);
    end
    if (TXD_Wr) wr_count++;
  end

  // driver tasks
  task automatic drive(input bit ev, input logic [3:0] ec, input bit cv, input logic [3:0] cc,
                       input bit vv, input logic [3:0] vc, input bit full);
    @(posedge Clk);
    #1;
    Error_Valid               = ev;
    Config_Error              = ec;
    Config_Notification_Valid = cv;
    Config_Notification       = cc;
    VGA_Notification_Valid    = vv;
    VGA_Notification          = vc;
    Full                      = full;
  endtask

  task automatic idle(input int n, input bit full);
    for (int i = 0; i < n; i++) drive(0, 4'h0, 0, 4'h0, 0, 4'h0, full);
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    idle(2, 0);
    Rst = 1'b1;
  endtask

  initial begin
    Rst = 1'b0;
    Error_Valid = 0; Config_Error = 0;
    Config_Notification_Valid = 0; Config_Notification = 0;
    VGA_Notification_Valid = 0; VGA_Notification = 0;
    Full = 0;
    idle(3, 0);
    check("rst_wr", {31'b0, TXD_Wr}, 32'h0);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_drops", {24'b0, Drop_Count}, 32'h0);
    Rst = 1'b1;
    idle(2, 0);

    // single error frame
    drive(1, 4'hA, 0, 4'h0, 0, 4'h0, 0);
    idle(10, 0);

    // three sources in one cycle
    drive(1, 4'h1, 1, 4'h3, 1, 4'h7, 0);
    idle(25, 0);
    check("t2_drops", {24'b0, Drop_Count}, 32'h0);

    // FIFO full stall on the second byte
    drive(1, 4'hA, 0, 4'h0, 0, 4'h0, 0);
    idle(2, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 4'h0, 0, 4'h0, 0, 4'h0, 1);
      #3;
      check("t3_hold", {24'b0, TXD_Data}, 32'h30);
    end
    idle(10, 0);

    // recapture after consume, then drop while pending
    drive(0, 4'h0, 1, 4'h5, 0, 4'h0, 0);
    idle(2, 0);
    drive(0, 4'h0, 1, 4'h6, 0, 4'h0, 0);
    idle(2, 0);
    drive(0, 4'h0, 1, 4'h9, 0, 4'h0, 0);
    idle(20, 0);
    check("t4_drops", {24'b0, Drop_Count}, 32'h1);

    // random traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 7) == 0, 4'($urandom), $urandom_range(0, 7) == 0, 4'($urandom),
            $urandom_range(0, 7) == 0, 4'($urandom), $urandom_range(0, 3) == 0);
    idle(30, 0);
    check("rand_drain", {31'b0, Busy}, 32'h0);

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 300; i++) drive(0, 4'h0, 0, 4'h0, 1, 4'($urandom), 1);
    idle(1, 1);
    check("t5_sat", {24'b0, Drop_Count}, 32'hFF);
    idle(20, 0);

    // asynchronous reset in the middle of a frame
    drive(1, 4'h2, 0, 4'h0, 0, 4'h0, 0);
    idle(2, 0);
    @(posedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    check("t6_wr", {31'b0, TXD_Wr}, 32'h0);
    check("t6_busy", {31'b0, Busy}, 32'h0);
    idle(3, 0);
    Rst = 1'b1;
    idle(5, 0);
    wr_count = 0;
    drive(0, 4'h0, 0, 4'h0, 1, 4'hC, 0);
    idle(12, 0);
    check("t6_frame_len", 32'(wr_count), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
